// File: rtl/s3ga_wb_pkg.sv
// Shared types and constants for the s3ga Wishbone classic initiator.
package s3ga_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int DEF_ADR_W = 32;
    localparam int DEF_DAT_W = 32;

    // Data returned with a timed-out transfer (sliced to DAT_W by the user).
    localparam logic [63:0] TIMEOUT_RESP_DAT = 64'd0;

endpackage

// File: rtl/s3ga_wb_master.sv
// Wishbone classic single-transfer initiator: one bus cycle per command,
// result on a valid/ready response channel, with a no-ack watchdog.
module s3ga_wb_master
    import s3ga_wb_pkg::*;
#(
    parameter int ADR_W   = DEF_ADR_W,
    parameter int DAT_W   = DEF_DAT_W,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_W-1:0]     cmd_adr,
    input  logic [DAT_W-1:0]     cmd_dat,
    input  logic [DAT_W/8-1:0]   cmd_sel,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DAT_W-1:0]     resp_dat,
    output logic                 resp_err,

    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [DAT_W/8-1:0]   wbm_sel_o,
    output logic [ADR_W-1:0]     wbm_adr_o,
    output logic [DAT_W-1:0]     wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [DAT_W-1:0]     wbm_dat_i
);

    localparam int SEL_W = DAT_W / 8;
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DAT_W-1:0] TO_DAT   = TIMEOUT_RESP_DAT[DAT_W-1:0];

    wb_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cyc_q;
    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [ADR_W-1:0]   adr_q;
    logic [DAT_W-1:0]   wdat_q;
    logic               rvalid_q;
    logic [DAT_W-1:0]   rdat_q;
    logic               rerr_q;

    // Ready depends only on state (and reset), never on cmd_valid.
    assign cmd_ready  = (state_q == IDLE) && !wb_rst_i;

    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = wdat_q;
    assign resp_valid = rvalid_q;
    assign resp_dat   = rdat_q;
    assign resp_err   = rerr_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            wdat_q   <= '0;
            rvalid_q <= 1'b0;
            rdat_q   <= '0;
            rerr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        sel_q   <= cmd_sel;
                        adr_q   <= cmd_adr;
                        wdat_q  <= cmd_dat;
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a watchdog expiry on the same edge.
                    if (wbm_ack_i) begin
                        cyc_q    <= 1'b0;
                        rdat_q   <= we_q ? '0 : wbm_dat_i;
                        rerr_q   <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        cyc_q    <= 1'b0;
                        rdat_q   <= TO_DAT;
                        rerr_q   <= 1'b1;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    cyc_q    <= 1'b0;
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s3ga_wb_master.sv
// Directed bench for s3ga_wb_master with a scoreboard of expected responses.
module tb_s3ga_wb_master;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;
    localparam int TO    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid, cmd_ready, cmd_we;
    logic [ADR_W-1:0]   cmd_adr;
    logic [DAT_W-1:0]   cmd_dat;
    logic [SEL_W-1:0]   cmd_sel;
    logic               resp_valid, resp_ready, resp_err;
    logic [DAT_W-1:0]   resp_dat;
    logic               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [SEL_W-1:0]   wbm_sel_o;
    logic [ADR_W-1:0]   wbm_adr_o;
    logic [DAT_W-1:0]   wbm_dat_o, wbm_dat_i;

    always #5 clk = ~clk;

    s3ga_wb_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dat(resp_dat), .resp_err(resp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    // Slave model: acks in the (ack_delay+1)-th cycle of cyc when enabled.
    int          ack_delay = 0;
    bit          ack_en    = 1'b0;
    bit          stray_ack = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          wcnt      = 0;
    int          cyc_total = 0;
    int          ncyc      = 0;

    assign wbm_ack_i = (wbm_cyc_o && ack_en && (wcnt == ack_delay)) || stray_ack;
    assign wbm_dat_i = slv_rdata;

    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        if (wbm_cyc_o) begin
            wcnt      <= wcnt + 1;
            cyc_total <= cyc_total + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Bus hygiene: stb mirrors cyc, and fields stay put while cyc is held.
    logic [68:0] prev_fields;
    logic        prev_cyc = 1'b0;
    always @(negedge clk) begin
        chk("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
        if (wbm_cyc_o && prev_cyc)
            chk("fields_stable", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, prev_fields);
        prev_cyc    = wbm_cyc_o;
        prev_fields = {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
    end

    typedef struct {
        logic [DAT_W-1:0] dat;
        logic             err;
    } exp_t;
    exp_t sbq[$];

    int cyc_start;

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] edat, input logic eerr,
                        output int hs_cyc);
        exp_t e;
        @(negedge clk);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        e.dat = edat; e.err = eerr;
        sbq.push_back(e);
        hs_cyc    = ncyc;
        cyc_start = cyc_total;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bus_cyc", wbm_cyc_o, 1'b1);
        chk("bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, {we, sel, adr, dat});
    endtask

    task automatic recv(input int max, output int rv_cyc);
        exp_t e;
        bit   seen = 1'b0;
        resp_ready = 1'b1;
        rv_cyc = -1;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        chk("resp_valid_seen", resp_valid, 1'b1);
        if (seen && sbq.size() > 0) begin
            e = sbq.pop_front();
            rv_cyc = ncyc;
            chk("resp_dat", resp_dat, e.dat);
            chk("resp_err", resp_err, e.err);
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_drop", resp_valid, 1'b0);
    endtask

    int hs, rv;
    exp_t e0;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                            resp_valid, resp_dat, resp_err}, '0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // Write with 2 wait states: cyc high 3 cycles, write response carries 0.
        ack_en = 1'b1; ack_delay = 2; slv_rdata = 32'hDEAD_BEEF;
        send(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, hs);
        recv(20, rv);
        chk("wr_cyc_cycles", cyc_total - cyc_start, 3);

        // Zero-wait read: response appears 2 cycles after the handshake cycle.
        ack_delay = 0; slv_rdata = 32'hCAFE_F00D;
        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, hs);
        recv(20, rv);
        chk("rd_latency", rv - hs, 2);

        // Slave never acks: watchdog fires after TO cycles of cyc.
        ack_en = 1'b0;
        send(1'b0, 32'h3000_0010, 32'h0, 4'h3, 32'h0, 1'b1, hs);
        recv(40, rv);
        chk("to_cyc_cycles", cyc_total - cyc_start, TO);

        // Next command after a timeout completes normally.
        ack_en = 1'b1; ack_delay = 1; slv_rdata = 32'h0BAD_F00D;
        send(1'b0, 32'h3000_0014, 32'h0, 4'hC, 32'h0BAD_F00D, 1'b0, hs);
        recv(20, rv);

        // Ack on the last BUS cycle beats the watchdog.
        ack_delay = TO - 1; slv_rdata = 32'h1234_5678;
        send(1'b0, 32'h3000_0018, 32'h0, 4'hF, 32'h1234_5678, 1'b0, hs);
        recv(40, rv);
        chk("ack_beats_to_cycles", cyc_total - cyc_start, TO);

        // Response back-pressure with a new command waiting.
        ack_delay = 0; slv_rdata = 32'h1111_2222;
        send(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h1111_2222, 1'b0, hs);
        @(negedge clk);
        @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 32'h3000_0024; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'h1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_resp", {resp_valid, resp_err, resp_dat}, {1'b1, 1'b0, 32'h1111_2222});
            @(negedge clk);
        end
        resp_ready = 1'b1;
        if (sbq.size() > 0) begin
            e0 = sbq.pop_front();
            chk("bp_resp_dat", resp_dat, e0.dat);
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        e0.dat = 32'h0; e0.err = 1'b0;
        sbq.push_back(e0);
        @(negedge clk);
        chk("bp_ready_after", {cmd_ready, resp_valid}, 2'b10);
        cyc_start = cyc_total;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_accept", {wbm_cyc_o, wbm_we_o, wbm_adr_o}, {1'b1, 1'b1, 32'h3000_0024});
        recv(20, rv);

        // Reset in the middle of a bus cycle.
        ack_en = 1'b0;
        send(1'b1, 32'h3000_0030, 32'h7777_8888, 4'hF, 32'h0, 1'b0, hs);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        sbq.delete();
        chk("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, resp_valid, cmd_ready}, 4'b0000);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_mid_ready", cmd_ready, 1'b1);
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ack_ignored", {wbm_cyc_o, resp_valid, cmd_ready}, 3'b001);
        end
        stray_ack = 1'b0;

        // Normal transfer after reset recovery.
        ack_en = 1'b1; ack_delay = 0; slv_rdata = 32'h600D_CAFE;
        send(1'b0, 32'h3000_0040, 32'h0, 4'hF, 32'h600D_CAFE, 1'b0, hs);
        recv(20, rv);
        chk("final_latency", rv - hs, 2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/s3ga_wb_master.md
Name: s3ga_wb_master

Overview:
Wishbone classic single-transfer initiator: the master end of the same Wishbone bus that s3ga_proj exposes as a slave.
Converts a valid/ready command stream (from the bench, LA bridge or config loader) into one Wishbone read or write per command. Returns the result on a valid/ready response channel.
Includes a bus-timeout watchdog so a non-responding slave cannot hang the initiator.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width (SEL_W = DAT_W/8)
TIMEOUT, 255, maximum cycles in BUS state without ack; must be >= 1

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  ADR_W  byte address
cmd_dat  in  DAT_W  write data
cmd_sel  in  SEL_W  byte enables
resp_valid  out  1  response available
resp_ready  in  1  response consumed when resp_valid & resp_ready
resp_dat  out  DAT_W  read data; 0 for writes and timeouts
resp_err  out  1  1 = transfer timed out
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  SEL_W  Wishbone byte select
wbm_adr_o  out  ADR_W  Wishbone address
wbm_dat_o  out  DAT_W  Wishbone write data
wbm_ack_i  in  1  Wishbone acknowledge
wbm_dat_i  in  DAT_W  Wishbone read data

Behaviour:
- State machine: IDLE, BUS, RESP.
- Reset state (synchronous, takes effect at the edge where wb_rst_i=1):
  - state=IDLE, timeout count=0.
  - All wbm_* outputs 0, resp_valid=0, resp_dat=0, resp_err=0.
  - cmd_ready is 0 while wb_rst_i is high.
- IDLE:
  - cmd_ready=1 (combinational from state, not from cmd_valid).
  - On handshake: register we/adr/dat/sel onto wbm_*, assert wbm_cyc_o=wbm_stb_o=1, counter=0, go to BUS.
- BUS:
  - cyc, stb and all wbm_* fields held stable; cmd_ready=0.
  - Each edge: if wbm_ack_i=1, drop cyc/stb, capture resp_dat = we ? 0 : wbm_dat_i, resp_err=0, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: drop cyc/stb, resp_dat=0, resp_err=1, go to RESP.
  - Otherwise counter++.
  - Ack sampled on the same edge that the timeout would fire: ack wins, resp_err=0.
- RESP:
  - resp_valid=1; resp_dat and resp_err stable until the handshake.
  - On resp_valid & resp_ready: resp_valid=0, go to IDLE.
  - No new command is accepted until the response is consumed; at most one transfer is outstanding.
- Latency with zero-wait slave (ack combinational while stb=1):
  - handshake at edge N, cyc high after N.
  - ack sampled at N+1, resp_valid high after N+1.
  - Back-to-back throughput is 1 transfer per 3 cycles when resp_ready is held 1.
- Bus hygiene:
  - wbm_ack_i outside BUS is ignored; it causes no state change.
  - wbm_stb_o == wbm_cyc_o always.
  - wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their last values after cyc drops. They are don't-care to the slave but must not toggle while cyc=1.
- Counter width: $clog2(TIMEOUT+1); no wrap possible, since it is cleared on BUS entry.
- Reset mid-transfer: cyc/stb go low at that edge, any pending response is discarded, state returns to IDLE.
- No pipelined or burst mode (no CTI/BTE, no err_i/rty_i).

Decomposition:
- Package s3ga_wb_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - localparams for the default ADR_W/DAT_W;
  - the timeout response data constant (0).
- Single module; no sub-module is warranted. The timeout counter stays inline.

Test Plan:
- Write adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks after 2 wait states -> cyc high exactly 3 cycles, wbm_* fields match, resp_valid with resp_dat=0, resp_err=0.
- Read adr=0x3000_0000; slave acks immediately with 0xCAFE_F00D -> resp_valid 2 cycles after the command handshake, resp_dat=0xCAFE_F00D, resp_err=0.
- TIMEOUT=8 with the slave never acking -> cyc high exactly 8 cycles, then resp_err=1, resp_dat=0; a later command completes normally.
- TIMEOUT=8 with ack on the 8th BUS cycle -> resp_err=0 and data captured (ack beats timeout).
- Hold resp_ready=0 for 5 cycles with cmd_valid held 1 -> cmd_ready stays 0 and resp_* stays stable. Then resp_ready=1 -> the next command is accepted the cycle after the response handshake.
- Assert wb_rst_i during BUS -> next cycle cyc=stb=0, resp_valid=0, cmd_ready=1 after reset releases, and a stray ack arriving afterwards is ignored.
